bram_writer: RTL and testbench

Receive-side counterpart of the BRAM A read path. Takes bytes from the UART receiver and writes them sequentially into port A of BRAM A, starting at address 0, until `N_BYTES` bytes have been stored. It then reports completion to the coprocessor control FSM. It also flags receive overruns and inter-byte timeouts so the controller can abort a stalled load.

---
 rtl/bram_writer_if.sv | 28 ++
 rtl/bram_writer.sv | 139 +++++++++++++
 tb/tb_bram_writer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bram_writer_if.sv
// Byte-load bus between the UART receive path, BRAM A port A and the control FSM.
// master drives start/rx_*; slave (bram_writer) drives the BRAM port and status.
interface bram_writer_if #(
    parameter int unsigned ADDR_W = 10
);
    localparam int unsigned DATA_W = 8;

    logic              start;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              busy;
    logic              write_done;
    logic              error;

    modport master (
        output start, rx_data, rx_ready,
        input  ena, wea, addra, dina, busy, write_done, error
    );

    modport slave (
        input  start, rx_data, rx_ready,
        output ena, wea, addra, dina, busy, write_done, error
    );
endinterface

// File: rtl/bram_writer.sv
// Streams received UART bytes into BRAM A port A from address 0 until N_BYTES are stored,
// flagging overruns and inter-byte timeouts through a sticky error bit.
module bram_writer #(
    parameter int unsigned N_BYTES        = 1024,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    bram_writer_if.slave bus
);
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IDX_W      = ADDR_W + 1;
    localparam int unsigned TCNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_BYTES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_error;
    logic                r_ena;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [TCNT_W-1:0]   w_tcnt_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_error_nxt;
    logic                w_ena_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output logic; outputs are decoded from the next state so they register cleanly
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tcnt_nxt  = r_tcnt;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_error_nxt = r_error;

        unique case (r_state)
            S_IDLE: begin
                // A coincident rx_ready is dropped: the load has not started yet
                if (bus.start) begin
                    w_idx_nxt   = '0;
                    w_tcnt_nxt  = '0;
                    w_error_nxt = 1'b0;
                    w_state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (bus.rx_ready) begin
                    w_data_nxt  = bus.rx_data;
                    w_addr_nxt  = r_idx[ADDR_W-1:0];
                    w_state_nxt = S_WRITE;
                end else if (TIMEOUT_EN && (r_tcnt == TCNT_LAST)) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                end
            end
            S_WRITE: begin
                // A byte arriving while the write is in flight is lost; flag it but keep loading
                w_idx_nxt  = r_idx + IDX_W'(1);
                w_tcnt_nxt = '0;
                if (bus.rx_ready) begin
                    w_error_nxt = 1'b1;
                end
                w_state_nxt = (r_idx == IDX_LAST) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ena_nxt  = (w_state_nxt == S_WRITE);
        w_busy_nxt = (w_state_nxt == S_RECV) || (w_state_nxt == S_WRITE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_tcnt  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_error <= 1'b0;
            r_ena   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_error <= w_error_nxt;
            r_ena   <= w_ena_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.ena        = r_ena;
    assign bus.wea        = r_ena;
    assign bus.addra      = r_addr;
    assign bus.dina       = r_data;
    assign bus.busy       = r_busy;
    assign bus.write_done = r_done;
    assign bus.error      = r_error;

endmodule

// File: tb/tb_bram_writer.sv
// Directed bench for bram_writer: a small instance (4 bytes, 50-cycle timeout) driven by a
// cycle vector table plus corner sequences, and a full 1024-byte instance.
module tb_bram_writer;

    logic clk = 1'b0;
    logic rst_small = 1'b0;
    logic rst_full  = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   full_writes = 0;
    int   full_dones  = 0;

    always #5 clk = ~clk;

    bram_writer_if #(.ADDR_W(10)) if_small ();
    bram_writer_if #(.ADDR_W(10)) if_full ();

    bram_writer #(.N_BYTES(4), .ADDR_W(10), .TIMEOUT_CYCLES(50)) dut_small (
        .clk (clk),
        .rst (rst_small),
        .bus (if_small)
    );

    bram_writer #(.N_BYTES(1024), .ADDR_W(10), .TIMEOUT_CYCLES(1_000_000)) dut_full (
        .clk (clk),
        .rst (rst_full),
        .bus (if_full)
    );

    always @(posedge clk) begin
        if (if_full.ena && if_full.wea) full_writes <= full_writes + 1;
        if (if_full.write_done)         full_dones  <= full_dones + 1;
    end

    typedef struct {
        logic       rs;
        logic       st;
        logic       rr;
        logic [7:0] d;
        logic       wr;
        logic [9:0] a;
        logic [7:0] q;
        logic       bz;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic rs, input logic st, input logic rr, input logic [7:0] d,
                                input logic wr, input logic [9:0] a, input logic [7:0] q,
                                input logic bz, input logic dn, input logic er);
        vec_t v;
        v.rs = rs; v.st = st; v.rr = rr; v.d = d;
        v.wr = wr; v.a = a; v.q = q; v.bz = bz; v.dn = dn; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle on the small instance: drive at negedge, sample just after the next rising edge
    task automatic apply(input logic rs, input logic st, input logic rr, input logic [7:0] d);
        @(negedge clk);
        rst_small         = rs;
        if_small.start    = st;
        if_small.rx_ready = rr;
        if_small.rx_data  = d;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_small(input string tag, input logic wr, input logic [9:0] a, input logic [7:0] q,
                             input logic bz, input logic dn, input logic er);
        chk({tag, " ena"},        32'(if_small.ena),        32'(wr));
        chk({tag, " wea"},        32'(if_small.wea),        32'(wr));
        chk({tag, " addra"},      32'(if_small.addra),      32'(a));
        chk({tag, " dina"},       32'(if_small.dina),       32'(q));
        chk({tag, " busy"},       32'(if_small.busy),       32'(bz));
        chk({tag, " write_done"}, 32'(if_small.write_done), 32'(dn));
        chk({tag, " error"},      32'(if_small.error),      32'(er));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wait;
        int dones;
        int writes;

        if_small.start = 1'b0; if_small.rx_ready = 1'b0; if_small.rx_data = 8'h00;
        if_full.start  = 1'b0; if_full.rx_ready  = 1'b0; if_full.rx_data  = 8'h00;

        //              rs st rr data   wr addr   dina  bz dn er
        vecs[0]  = mk(0, 0, 0, 8'h00, 0, 10'd0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 8'h00, 0, 10'd0, 8'h00, 0, 0, 0);
        vecs[2]  = mk(1, 0, 1, 8'h77, 0, 10'd0, 8'h00, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 8'h00, 0, 10'd0, 8'h00, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 8'h00, 0, 10'd0, 8'h00, 1, 0, 0);
        vecs[5]  = mk(1, 0, 1, 8'hA5, 1, 10'd0, 8'hA5, 1, 0, 0);
        vecs[6]  = mk(1, 1, 0, 8'h00, 0, 10'd0, 8'hA5, 1, 0, 0);
        vecs[7]  = mk(1, 0, 1, 8'h5A, 1, 10'd1, 8'h5A, 1, 0, 0);
        vecs[8]  = mk(1, 0, 0, 8'h00, 0, 10'd1, 8'h5A, 1, 0, 0);
        vecs[9]  = mk(1, 0, 1, 8'hFF, 1, 10'd2, 8'hFF, 1, 0, 0);
        vecs[10] = mk(1, 0, 0, 8'h00, 0, 10'd2, 8'hFF, 1, 0, 0);
        vecs[11] = mk(1, 0, 1, 8'h00, 1, 10'd3, 8'h00, 1, 0, 0);
        vecs[12] = mk(1, 0, 0, 8'h00, 0, 10'd3, 8'h00, 0, 1, 0);
        vecs[13] = mk(1, 0, 0, 8'h00, 0, 10'd3, 8'h00, 0, 0, 0);
        vecs[14] = mk(1, 1, 1, 8'h99, 0, 10'd3, 8'h00, 1, 0, 0);
        vecs[15] = mk(1, 0, 1, 8'h11, 1, 10'd0, 8'h11, 1, 0, 0);
        vecs[16] = mk(1, 0, 1, 8'h22, 0, 10'd0, 8'h11, 1, 0, 1);
        vecs[17] = mk(1, 0, 1, 8'h33, 1, 10'd1, 8'h33, 1, 0, 1);
        vecs[18] = mk(1, 0, 0, 8'h00, 0, 10'd1, 8'h33, 1, 0, 1);
        vecs[19] = mk(1, 0, 1, 8'h44, 1, 10'd2, 8'h44, 1, 0, 1);
        vecs[20] = mk(1, 0, 0, 8'h00, 0, 10'd2, 8'h44, 1, 0, 1);
        vecs[21] = mk(1, 0, 1, 8'h55, 1, 10'd3, 8'h55, 1, 0, 1);
        vecs[22] = mk(1, 0, 0, 8'h00, 0, 10'd3, 8'h55, 0, 1, 1);
        vecs[23] = mk(1, 0, 0, 8'h00, 0, 10'd3, 8'h55, 0, 0, 1);
        vecs[24] = mk(1, 1, 0, 8'h00, 0, 10'd3, 8'h55, 1, 0, 0);
        vecs[25] = mk(1, 0, 1, 8'h01, 1, 10'd0, 8'h01, 1, 0, 0);
        vecs[26] = mk(1, 0, 0, 8'h00, 0, 10'd0, 8'h01, 1, 0, 0);
        vecs[27] = mk(1, 0, 1, 8'h02, 1, 10'd1, 8'h02, 1, 0, 0);
        vecs[28] = mk(1, 0, 0, 8'h00, 0, 10'd1, 8'h02, 1, 0, 0);

        #1;
        chk("full reset ena",  32'(if_full.ena),  32'd0);
        chk("full reset busy", 32'(if_full.busy), 32'd0);

        // Small instance: reset, normal load, ignored strobes, overrun, start of a timeout load
        for (int i = 0; i < 29; i++) begin
            apply(vecs[i].rs, vecs[i].st, vecs[i].rr, vecs[i].d);
            chk_small($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].q,
                      vecs[i].bz, vecs[i].dn, vecs[i].er);
        end

        // Timeout: silence after the second write must abort after exactly 50 waiting cycles
        n_wait = 0; dones = 0; writes = 0;
        for (int c = 0; c < 60; c++) begin
            apply(1, 0, 0, 8'h00);
            n_wait++;
            if (if_small.write_done) dones++;
            if (if_small.ena) writes++;
            if (!if_small.busy) break;
        end
        chk("timeout cycles", 32'(n_wait), 32'd50);
        chk("timeout busy",   32'(if_small.busy), 32'd0);
        chk("timeout error",  32'(if_small.error), 32'd1);
        chk("timeout done",   32'(dones), 32'd0);
        chk("timeout writes", 32'(writes), 32'd0);

        // Reset asserted between edges mid-load
        apply(1, 1, 0, 8'h00);
        chk_small("rs start", 0, 10'd1, 8'h02, 1, 0, 0);
        apply(1, 0, 1, 8'hC1);
        apply(1, 0, 0, 8'h00);
        apply(1, 0, 1, 8'hC2);
        apply(1, 0, 0, 8'h00);
        apply(1, 0, 1, 8'hC3);
        chk_small("rs byte3", 1, 10'd2, 8'hC3, 1, 0, 0);
        #2;
        rst_small = 1'b0;
        #1;
        chk_small("rs async", 0, 10'd0, 8'h00, 0, 0, 0);
        apply(0, 0, 0, 8'h00);
        apply(1, 0, 0, 8'h00);
        chk_small("rs idle", 0, 10'd0, 8'h00, 0, 0, 0);
        apply(1, 1, 0, 8'h00);
        chk_small("rs restart", 0, 10'd0, 8'h00, 1, 0, 0);
        apply(1, 0, 1, 8'hD0);
        chk_small("rs first", 1, 10'd0, 8'hD0, 1, 0, 0);
        apply(1, 0, 0, 8'h00);
        chk_small("rs after", 0, 10'd0, 8'hD0, 1, 0, 0);

        // Full 1024-byte load, 20-cycle byte spacing, address range reaching 2^ADDR_W
        @(negedge clk);
        rst_full = 1'b1;
        @(negedge clk);
        if_full.start = 1'b1;
        @(negedge clk);
        if_full.start = 1'b0;
        chk("full busy after start", 32'(if_full.busy), 32'd1);
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if_full.rx_ready = 1'b1;
            if_full.rx_data  = 8'(i);
            @(posedge clk);
            #2;
            chk($sformatf("full ena %0d", i),   32'(if_full.ena & if_full.wea), 32'd1);
            chk($sformatf("full addra %0d", i), 32'(if_full.addra), 32'(i));
            chk($sformatf("full dina %0d", i),  32'(if_full.dina),  32'(i & 255));
            @(negedge clk);
            if_full.rx_ready = 1'b0;
            if (i == 1023) begin
                @(posedge clk);
                #2;
                chk("full write_done", 32'(if_full.write_done), 32'd1);
                chk("full busy at done", 32'(if_full.busy), 32'd0);
                chk("full ena at done", 32'(if_full.ena), 32'd0);
                @(posedge clk);
                #2;
                chk("full write_done pulse", 32'(if_full.write_done), 32'd0);
            end else begin
                repeat (18) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        chk("full write count", 32'(full_writes), 32'd1024);
        chk("full done count",  32'(full_dones),  32'd1);
        chk("full error",       32'(if_full.error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
